fft4_frame_loader: RTL
======================

# fft4_frame_loader

Input framing stage directly upstream of the 4-point FFT butterfly. Accepts a serial stream of 4-bit samples over a valid/ready handshake, groups every four consecutive samples into one frame, and presents the frame in parallel as the four butterfly operands (`a`, `b`, `c`, `d`). Two frame banks (ping-pong) allow one frame to fill while the other is held for the FFT consumer, sustaining one sample per cycle.

## Interface

**Parameters**
- `SAMPLE_W`, default 4: sample width; matches the FFT operand width.
- `CNT_W`, default 16: width of the frame counter.

**Ports**
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: upstream sample valid.
- `s_ready`, out, 1: loader can accept a sample this cycle.
- `s_data`, in, `SAMPLE_W`: sample value, unsigned.
- `s_sof`, in, 1: start-of-frame marker, qualified by `s_valid && s_ready`.
- `m_valid`, out, 1: a complete frame is presented.
- `m_ready`, in, 1: FFT side consumes the frame.
- `m_a`, `m_b`, `m_c`, `m_d`, out, `SAMPLE_W` each: frame samples, time indices 0..3.
- `frame_cnt`, out, `CNT_W`: count of frames handed off; wraps.
- `drop_cnt`, out, 8: count of partial frames discarded by resync; saturates at 255.

## Operation

**State**
- `bank[0:1][0:3]`: sample registers.
- `full[0:1]`: per-bank full flags.
- `wr_bank`, `rd_bank`: 1-bit bank pointers.
- `wr_idx`: 2-bit slot pointer.
- `frame_cnt`, `drop_cnt`: counters.

**Write side**
- `s_ready = !full[wr_bank]`.
- A sample is accepted on `s_valid && s_ready`. It is written to `bank[wr_bank][slot(wr_idx)]`, and `wr_idx` increments.
- When the accepted sample has `wr_idx == 3`:
  - `full[wr_bank]` is set.
  - `wr_bank` toggles.
  - `wr_idx` returns to 0.

**Resync**
- If an accepted sample has `s_sof = 1` and `wr_idx != 0`:
  - The partial frame is discarded.
  - The sample is written to slot 0.
  - `wr_idx` becomes 1.
  - `drop_cnt` increments, saturating.
- `s_sof` with `wr_idx == 0` is a normal sample with no drop.
- Resync never touches a bank that is already full.

**Read side**
- `m_valid = full[rd_bank]`.
- `m_a..m_d = bank[rd_bank][0..3]`, driven directly from registers.
- On `m_valid && m_ready`:
  - `full[rd_bank]` clears.
  - `rd_bank` toggles.
  - `frame_cnt` increments, wrapping at 2^`CNT_W`.

**Handshake rules**
- While `m_valid` is high, `m_a..m_d` hold stable until consumed.
- Upstream must hold `s_data`/`s_sof` while `s_valid && !s_ready`.

**Simultaneous events**
- Frame completion on one bank and consumption of the other bank in the same cycle both take effect.
- When both banks are full, `s_ready = 0`. A consume in that cycle raises `s_ready` on the next cycle, never combinationally from `m_ready`.

**Reset (asynchronous, any time including mid-frame)**
- All bank registers, flags, pointers and counters clear; any partial or pending frame is lost.
- Output values while reset is asserted and after release:
  - `m_valid = 0`
  - `m_a..m_d = 0`
  - `frame_cnt = 0`
  - `drop_cnt = 0`
  - `s_ready = 1`

## Timing

- **Latency:** the fourth sample of a frame is accepted at edge N; `m_valid` is high from edge N (visible in cycle N+1) with that frame on `m_a..m_d`.
- **Throughput:** one sample per cycle, sustained indefinitely, provided the consumer accepts each frame within 4 cycles of `m_valid`.
- **Backpressure:** with `m_ready` held low, exactly 8 samples are accepted before `s_ready` drops.
- **Paths:** no combinational path from any input to any output except `s_ready`/`m_valid`, which are decoded from registered state.

## Configuration

- `FFT4_LOADER_BITREV_EN`
  - **Defined:** slot mapping is bit-reversed, `slot(i) = {i[0], i[1]}`. Time samples 0,1,2,3 appear on `m_a`, `m_c`, `m_b`, `m_d` respectively, giving decimation-in-time input order.
  - **Undefined:** `slot(i) = i`, natural order.
- All handshake, counter and resync behaviour is identical in both builds.

## Structure

- **Shared package `fft4_pkg`:**
  - `SAMPLE_W` default.
  - `typedef logic [SAMPLE_W-1:0] sample_t`.
  - `typedef sample_t frame_t [4]`.
  - The `slot` bit-reverse function, shared with the 8-point loader.
- **Sub-module `fft4_bank`:** one 4-entry sample bank with write-enable/slot-index input and full flag, instantiated twice. The ping-pong control stays in the top level.

## Test plan

1. **Reset then first frame.** Reset, then stream 1,2,3,4 with `m_ready = 1` → `m_valid` one cycle after the 4th accept with `m_a..m_d` = 1,2,3,4 (bitrev build: 1,3,2,4); `frame_cnt` = 1.
2. **Continuous stream.** 40 back-to-back samples 0..39 with `m_ready = 1` → `s_ready` never drops; 10 frames in order; `frame_cnt` = 10.
3. **Backpressure.** `m_ready = 0` with continuous `s_valid` → exactly 8 accepts, then `s_ready = 0`. Raise `m_ready` for one cycle → frame {0,1,2,3} consumed and `s_ready` returns next cycle.
4. **Resync.** Send 5,6, then 9 with `s_sof = 1`, then 10,11,12 → single frame {9,10,11,12}; `drop_cnt` = 1. Repeat 300 times → `drop_cnt` saturates at 255.
5. **Simultaneous completion and consume.** Bank 0 full and presented; complete bank 1 in the same cycle `m_ready = 1` → bank 0 consumed, bank 1 presented next cycle, no sample lost.
6. **Reset mid-frame.** Assert `rst_n` low after 2 samples with one full frame pending → immediately `m_valid = 0` and `s_ready = 1`; after release, the next 4 samples form the first frame.

Source files
------------

// File: rtl/fft4_pkg.sv
// Shared types and helpers for the FFT input loaders.
// FFT4_LOADER_BITREV_EN: when defined, slot() returns the bit-reversed index
// so frames come out in decimation-in-time order.
package fft4_pkg;

  localparam int unsigned SAMPLE_W = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t frame_t [4];

  // Map a time index within a frame to its storage slot
  function automatic logic [1:0] slot(input logic [1:0] i);
`ifdef FFT4_LOADER_BITREV_EN
    return {i[0], i[1]};
`else
    return i;
`endif
  endfunction

endpackage

// File: rtl/fft4_bank.sv
// One 4-entry sample bank with a full flag; written one slot at a time.
module fft4_bank #(
  parameter int unsigned SAMPLE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_slot,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                set_full,
  input  logic                clr_full,
  output logic                full,
  output logic [SAMPLE_W-1:0] data [4]
);

  logic [SAMPLE_W-1:0] data_q [4];
  logic [SAMPLE_W-1:0] data_d [4];
  logic                full_q;
  logic                full_d;

  // Next-state: slot write and full flag set/clear
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (wr_en) begin
      data_d[wr_slot] = wr_data;
    end
    if (set_full) begin
      full_d = 1'b1;
    end else if (clr_full) begin
      full_d = 1'b0;
    end
  end

  // Bank storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/fft4_frame_loader.sv
// Ping-pong framing stage: serial samples in, 4-sample frames out to the FFT.
// FFT4_LOADER_BITREV_EN selects bit-reversed slot order (see fft4_pkg::slot).
module fft4_frame_loader #(
  parameter int unsigned SAMPLE_W = fft4_pkg::SAMPLE_W,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_sof,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SAMPLE_W-1:0] m_a,
  output logic [SAMPLE_W-1:0] m_b,
  output logic [SAMPLE_W-1:0] m_c,
  output logic [SAMPLE_W-1:0] m_d,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [7:0]          drop_cnt
);

  import fft4_pkg::*;

  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          wr_idx_q, wr_idx_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic                full0, full1;
  logic [SAMPLE_W-1:0] bank0_data [4];
  logic [SAMPLE_W-1:0] bank1_data [4];

  logic                accept;
  logic                consume;
  logic                resync;
  logic                complete;
  logic [1:0]          wr_slot;

  // Handshake decode from registered bank state
  assign s_ready = wr_bank_q ? !full1 : !full0;
  assign m_valid = rd_bank_q ? full1 : full0;
  assign accept  = s_valid && s_ready;
  assign consume = m_valid && m_ready;

  // Pointer and counter next-state; resync wins over frame completion
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_idx_d    = wr_idx_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    resync      = 1'b0;
    complete    = 1'b0;
    wr_slot     = slot(wr_idx_q);

    if (accept) begin
      if (s_sof && (wr_idx_q != 2'd0)) begin
        resync   = 1'b1;
        wr_slot  = slot(2'd0);
        wr_idx_d = 2'd1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end else if (wr_idx_q == 2'd3) begin
        complete  = 1'b1;
        wr_idx_d  = 2'd0;
        wr_bank_d = !wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 2'd1;
      end
    end

    if (consume) begin
      rd_bank_d   = !rd_bank_q;
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= 2'd0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= 8'd0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fft4_bank #(.SAMPLE_W(SAMPLE_W)) u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept && !wr_bank_q),
    .wr_slot  (wr_slot),
    .wr_data  (s_data),
    .set_full (complete && !wr_bank_q),
    .clr_full (consume && !rd_bank_q),
    .full     (full0),
    .data     (bank0_data)
  );

  fft4_bank #(.SAMPLE_W(SAMPLE_W)) u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept && wr_bank_q),
    .wr_slot  (wr_slot),
    .wr_data  (s_data),
    .set_full (complete && wr_bank_q),
    .clr_full (consume && rd_bank_q),
    .full     (full1),
    .data     (bank1_data)
  );

  // Present the read bank straight from its registers
  assign m_a = rd_bank_q ? bank1_data[0] : bank0_data[0];
  assign m_b = rd_bank_q ? bank1_data[1] : bank0_data[1];
  assign m_c = rd_bank_q ? bank1_data[2] : bank0_data[2];
  assign m_d = rd_bank_q ? bank1_data[3] : bank0_data[3];

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
